counter_1: RTL and testbench

//   Free-running modulo counter driving an 8-bit value bus (DUT name counter1).

---
 rtl/counter_1_pkg.sv | 13 +
 rtl/counter_1_next.sv | 38 +++
 rtl/counter_1.sv | 49 ++++
 tb/tb_counter_1.sv | 132 +++++++++++++
 4 files changed

// File: rtl/counter_1_pkg.sv
// Shared defaults and direction encoding for the counter_1 modulo counter.
package counter_1_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_MAX_VAL = 255;
  localparam int unsigned DEF_STEP    = 1;

  typedef enum logic {
    CNT_UP = 1'b0,
    CNT_DN = 1'b1
  } cnt_dir_e;

endpackage : counter_1_pkg

// File: rtl/counter_1_next.sv
// Combinational next-count function: advances q by STEP in the given
// direction and wraps into 0..MAX_VAL, using one spare bit of headroom.
module counter_1_next
  import counter_1_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MAX_VAL = DEF_MAX_VAL,
  parameter int unsigned STEP    = DEF_STEP
) (
  input  logic [WIDTH-1:0] q_i,
  input  cnt_dir_e         dir_i,
  output logic [WIDTH-1:0] next_c
);

  localparam int unsigned EW = WIDTH + 1;

  localparam logic [EW-1:0] STEP_X = EW'(STEP);
  localparam logic [EW-1:0] MOD_X  = EW'(MAX_VAL) + EW'(1);
  localparam logic [EW-1:0] UP_LIM = EW'(MAX_VAL - STEP);

  logic [EW-1:0] q_x;
  logic [EW-1:0] sum_x;

  // Wrap test is done before the add/subtract so no intermediate leaves EW bits.
  always_comb begin
    q_x   = EW'(q_i);
    sum_x = '0;
    if (dir_i == CNT_DN) begin
      if (q_x < STEP_X) sum_x = q_x + MOD_X - STEP_X;
      else              sum_x = q_x - STEP_X;
    end else begin
      if (q_x > UP_LIM) sum_x = q_x + STEP_X - MOD_X;
      else              sum_x = q_x + STEP_X;
    end
    next_c = WIDTH'(sum_x);
  end

endmodule : counter_1_next

// File: rtl/counter_1.sv
// Free-running modulo counter: count register with synchronous reset and
// elaboration-time parameter sanity checks.
module counter_1
  import counter_1_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MAX_VAL = DEF_MAX_VAL,
  parameter int unsigned STEP    = DEF_STEP,
  parameter int unsigned DOWN    = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  localparam cnt_dir_e DIR = (DOWN != 0) ? CNT_DN : CNT_UP;

  if (64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("counter_1: MAX_VAL does not fit in WIDTH bits");
  end
  if (STEP == 0) begin : g_bad_step_zero
    $error("counter_1: STEP must be at least 1");
  end
  if (STEP > MAX_VAL) begin : g_bad_step_big
    $error("counter_1: STEP must not exceed MAX_VAL");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  counter_1_next #(
    .WIDTH  (WIDTH),
    .MAX_VAL(MAX_VAL),
    .STEP   (STEP)
  ) u_next (
    .q_i   (q_q),
    .dir_i (DIR),
    .next_c(q_d)
  );

  // Reset wins over the pending count; no partial update.
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule : counter_1

// File: tb/tb_counter_1.sv
// Bench for counter_1: three configurations (default up, mod-10 step-3, down)
// checked against a modulo reference model through an expectation queue.
module tb_counter_1;

  logic       clk;
  logic       rst;
  logic [7:0] q_a;
  logic [7:0] q_b;
  logic [7:0] q_c;

  counter_1 u_a (.clk(clk), .rst(rst), .q(q_a));
  counter_1 #(.MAX_VAL(9), .STEP(3)) u_b (.clk(clk), .rst(rst), .q(q_b));
  counter_1 #(.DOWN(1)) u_c (.clk(clk), .rst(rst), .q(q_c));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } exp_t;

  typedef struct {
    logic       r;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[13];

  int total = 0;
  int bad   = 0;
  int ma = 0, mb = 0, mc = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: plain modulo arithmetic on integers.
  task automatic model_step(input logic r);
    if (r) begin
      ma = 0; mb = 0; mc = 0;
    end else begin
      ma = (ma + 1) % 256;
      mb = (mb + 3) % 10;
      mc = (mc + 256 - 1) % 256;
    end
  endtask

  // One clock: queue expectation, drive rst, check after the edge and at mid-cycle.
  task automatic drive(input logic r, input logic use_vec, input vec_t v);
    exp_t e;
    model_step(r);
    if (use_vec) begin
      e.a = v.a; e.b = v.b; e.c = v.c;
    end else begin
      e.a = 8'(ma); e.b = 8'(mb); e.c = 8'(mc);
    end
    sb_q.push_back(e);
    rst = r;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("q_a", q_a, e.a);
    chk("q_b", q_b, e.b);
    chk("q_c", q_c, e.c);
    @(negedge clk);
    chk("q_a_stable", q_a, e.a);
  endtask

  task automatic run(input logic r);
    vec_t dummy;
    dummy = '{1'b0, 8'd0, 8'd0, 8'd0};
    drive(r, 1'b0, dummy);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'd0,  8'd0, 8'd0};
    vecs[1]  = '{1'b1, 8'd0,  8'd0, 8'd0};
    vecs[2]  = '{1'b0, 8'd1,  8'd3, 8'd255};
    vecs[3]  = '{1'b0, 8'd2,  8'd6, 8'd254};
    vecs[4]  = '{1'b0, 8'd3,  8'd9, 8'd253};
    vecs[5]  = '{1'b0, 8'd4,  8'd2, 8'd252};
    vecs[6]  = '{1'b0, 8'd5,  8'd5, 8'd251};
    vecs[7]  = '{1'b0, 8'd6,  8'd8, 8'd250};
    vecs[8]  = '{1'b0, 8'd7,  8'd1, 8'd249};
    vecs[9]  = '{1'b0, 8'd8,  8'd4, 8'd248};
    vecs[10] = '{1'b0, 8'd9,  8'd7, 8'd247};
    vecs[11] = '{1'b0, 8'd10, 8'd0, 8'd246};
    vecs[12] = '{1'b0, 8'd11, 8'd3, 8'd245};

    rst = 1'b1;
    for (int i = 0; i < 13; i++) drive(vecs[i].r, 1'b1, vecs[i]);

    // Up-count wrap at the terminal count.
    for (int n = 0; n < 400 && ma != 255; n++) run(1'b0);
    chk("reach_ff", q_a, 8'hFF);
    run(1'b0);
    chk("wrap_0", q_a, 8'h00);
    run(1'b0);
    chk("wrap_1", q_a, 8'h01);

    // Reset in the middle of a count.
    for (int n = 0; n < 400 && ma != 8'h7A; n++) run(1'b0);
    chk("at_7a", q_a, 8'h7A);
    run(1'b1);
    chk("rst_mid", q_a, 8'h00);
    run(1'b1);
    chk("rst_hold", q_a, 8'h00);
    run(1'b0);
    chk("resume_a", q_a, 8'h01);
    chk("resume_b", q_b, 8'h03);
    chk("resume_c", q_c, 8'hFF);

    // Down-count wrap from 0 back to MAX_VAL.
    for (int n = 0; n < 400 && mc != 0; n++) run(1'b0);
    chk("dn_zero", q_c, 8'h00);
    run(1'b0);
    chk("dn_wrap", q_c, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_counter_1
